add_arb_16b: RTL and testbench
==============================

# add_arb_16b

Shared-adder arbiter and sequencer. Two requesters compete for a single 16-bit ripple-carry adder; the block grants one request at a time using round-robin arbitration. It captures the granted operands, runs the addition through a registered stage, and returns the sum, carry-out, signed-overflow flag and requester ID on one valid/ready response channel. It sits between the two requesting units and the one adder instance, so the design needs only one adder datapath.

## Interface
- N, 16, operand/result width (fixed at 16 by the adder sub-module)
- clk  input  1  clock, all state updates on rising edge
- rst  input  1  synchronous, active-high reset
- req0  input  1  requester 0 request; level, held with operands stable until ack0
- a0, b0  input  N each  requester 0 operands
- ack0  output  1  one-cycle grant/capture strobe for requester 0
- req1, a1, b1, ack1  as above, requester 1
- rsp_valid  output  1  response valid
- rsp_ready  input  1  consumer accepts response
- rsp_id  output  1  requester served (0/1)
- rsp_sum  output  N  A+B modulo 2^N
- rsp_cout  output  1  unsigned carry-out
- rsp_ovf  output  1  two's-complement overflow

## Operation
- FSM states: IDLE, ADD, HOLD.
- IDLE
  - If any req is high: pick a winner, assert that ack combinationally, latch its operands and ID into operand regs, update last_gnt, go to ADD.
  - Else stay in IDLE.
- Arbitration
  - One req high: it wins.
  - Both high: the requester not equal to last_gnt wins.
  - Reset sets last_gnt=1, so requester 0 wins the first tie.
- ADD
  - Adder evaluates the operand regs.
  - rsp_sum, rsp_cout and rsp_id load from the adder/operand regs.
  - rsp_ovf = (opA[15]==opB[15]) && (sum[15]!=opA[15]).
  - Go to HOLD.
- HOLD
  - rsp_valid=1; response regs hold.
  - If rsp_ready=1: go to IDLE.
  - Else stay in HOLD indefinitely, with no new acks.
- ack0/ack1 are high only in IDLE and never both high. reqs in ADD/HOLD are ignored, not lost; the requester keeps req high.
- Reset mid-operation: next state IDLE, rsp_valid=0, in-flight op discarded with no response, last_gnt=1.
- Arithmetic is modulo 2^16. cout and ovf are independent flags and may both be set.

## Timing
- Reset values:
  - ack0=ack1=0 during the reset cycle; ack is suppressed while rst=1.
  - rsp_valid=0, rsp_id=0, rsp_sum=0, rsp_cout=0, rsp_ovf=0.
  - state=IDLE, last_gnt=1.
- Cycle T: IDLE with req high → ack high in T; operands captured at the T edge.
- Cycle T+1: ADD.
- Cycle T+2: rsp_valid=1 with the result.
- Latency: 2 cycles from ack to rsp_valid.
- If rsp_ready=1 at T+2: IDLE at T+3, and the next ack is possible in T+3. Minimum spacing between acks is 3 cycles.
- The requester may change operands or drop req from T+1 onward.
- rsp_* remain stable while rsp_valid=1 && rsp_ready=0.
- rsp_ready while rsp_valid=0 has no effect.

## Structure
- Shared package add_arb_pkg holds:
  - state encodings ST_IDLE=2'd0, ST_ADD=2'd1, ST_HOLD=2'd2
  - ID constants ID_REQ0=1'b0, ID_REQ1=1'b1
  - width constant N=16
- Sub-module: one instance of the team's rca_16b (A, B, S, C_out, carry-in tied 0), used unchanged.
- Arbitration, operand regs, FSM and response regs are inline in add_arb_16b.
- Unused state encoding 2'd3 recovers to IDLE.

## Test plan
- Reset, then req0=1, a0=16'h0001, b0=16'h0002, rsp_ready=1 → ack0 in the first IDLE cycle; two cycles later rsp_valid=1, rsp_id=0, rsp_sum=16'h0003, cout=0, ovf=0; IDLE the next cycle.
- req1 alone with a1=16'hFFFF, b1=16'h0001 → rsp_id=1, sum=16'h0000, cout=1, ovf=0.
- a0=16'h7FFF, b0=16'h0001 → sum=16'h8000, cout=0, ovf=1. Also a0=b0=16'h8000 → sum=0, cout=1, ovf=1.
- Both reqs held high from reset, rsp_ready=1:
  - acks alternate 0,1,0,1, each 3 cycles apart;
  - ack0 and ack1 are never high together;
  - responses carry the matching IDs and sums.
- rsp_ready=0 for 5 cycles in HOLD, with req1 high → rsp_* stable throughout and no ack1. After rsp_ready=1, ack1 is asserted in the following IDLE cycle.
- rst asserted during ADD → next cycle rsp_valid=0, state IDLE, no response for the discarded op. A subsequent tie grants requester 0.

Source files
------------

// File: rtl/add_arb_pkg.sv
// Shared constants and types for the two-requester shared-adder arbiter.
package add_arb_pkg;

    localparam int unsigned N = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam logic ID_REQ0 = 1'b0;
    localparam logic ID_REQ1 = 1'b1;

    // Two's-complement overflow: like-signed operands yielding an opposite-signed sum.
    function automatic logic ovf_flag(input logic a_msb, input logic b_msb, input logic s_msb);
        return (a_msb == b_msb) && (s_msb != a_msb);
    endfunction

endpackage

// File: rtl/rca_16b.sv
// 16-bit ripple-carry adder with carry-in and carry-out.
module rca_16b (
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic        C_in,
    output logic [15:0] S,
    output logic        C_out
);

    logic [16:0] c;

    always_comb begin
        c    = '0;
        S    = '0;
        c[0] = C_in;
        for (int i = 0; i < 16; i++) begin
            S[i]     = A[i] ^ B[i] ^ c[i];
            c[i + 1] = (A[i] & B[i]) | (c[i] & (A[i] ^ B[i]));
        end
        C_out = c[16];
    end

endmodule

// File: rtl/add_arb_16b.sv
// Round-robin arbiter that shares one 16-bit adder between two requesters and
// returns each result on a single valid/ready response channel.
module add_arb_16b
    import add_arb_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         req0,
    input  logic [N-1:0] a0,
    input  logic [N-1:0] b0,
    output logic         ack0,
    input  logic         req1,
    input  logic [N-1:0] a1,
    input  logic [N-1:0] b1,
    output logic         ack1,
    output logic         rsp_valid,
    input  logic         rsp_ready,
    output logic         rsp_id,
    output logic [N-1:0] rsp_sum,
    output logic         rsp_cout,
    output logic         rsp_ovf
);

    state_e       state_q, state_d;
    logic [N-1:0] op_a_q, op_a_d;
    logic [N-1:0] op_b_q, op_b_d;
    logic         op_id_q, op_id_d;
    logic         last_gnt_q, last_gnt_d;
    logic         rsp_id_q, rsp_id_d;
    logic [N-1:0] rsp_sum_q, rsp_sum_d;
    logic         rsp_cout_q, rsp_cout_d;
    logic         rsp_ovf_q, rsp_ovf_d;

    logic         gnt_id;
    logic [N-1:0] add_sum;
    logic         add_cout;

    rca_16b u_rca (
        .A     (op_a_q),
        .B     (op_b_q),
        .C_in  (1'b0),
        .S     (add_sum),
        .C_out (add_cout)
    );

    always_comb begin
        state_d    = state_q;
        op_a_d     = op_a_q;
        op_b_d     = op_b_q;
        op_id_d    = op_id_q;
        last_gnt_d = last_gnt_q;
        rsp_id_d   = rsp_id_q;
        rsp_sum_d  = rsp_sum_q;
        rsp_cout_d = rsp_cout_q;
        rsp_ovf_d  = rsp_ovf_q;
        ack0       = 1'b0;
        ack1       = 1'b0;

        // On a tie the requester not served last time wins.
        if (req0 && req1) begin
            gnt_id = (last_gnt_q == ID_REQ0) ? ID_REQ1 : ID_REQ0;
        end else begin
            gnt_id = req1 ? ID_REQ1 : ID_REQ0;
        end

        case (state_q)
            ST_IDLE: begin
                if ((req0 || req1) && !rst) begin
                    ack0       = (gnt_id == ID_REQ0);
                    ack1       = (gnt_id == ID_REQ1);
                    op_a_d     = (gnt_id == ID_REQ1) ? a1 : a0;
                    op_b_d     = (gnt_id == ID_REQ1) ? b1 : b0;
                    op_id_d    = gnt_id;
                    last_gnt_d = gnt_id;
                    state_d    = ST_ADD;
                end
            end
            ST_ADD: begin
                rsp_id_d   = op_id_q;
                rsp_sum_d  = add_sum;
                rsp_cout_d = add_cout;
                rsp_ovf_d  = ovf_flag(op_a_q[N-1], op_b_q[N-1], add_sum[N-1]);
                state_d    = ST_HOLD;
            end
            ST_HOLD: begin
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            op_a_q     <= '0;
            op_b_q     <= '0;
            op_id_q    <= ID_REQ0;
            last_gnt_q <= ID_REQ1;
            rsp_id_q   <= 1'b0;
            rsp_sum_q  <= '0;
            rsp_cout_q <= 1'b0;
            rsp_ovf_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            op_a_q     <= op_a_d;
            op_b_q     <= op_b_d;
            op_id_q    <= op_id_d;
            last_gnt_q <= last_gnt_d;
            rsp_id_q   <= rsp_id_d;
            rsp_sum_q  <= rsp_sum_d;
            rsp_cout_q <= rsp_cout_d;
            rsp_ovf_q  <= rsp_ovf_d;
        end
    end

    assign rsp_valid = (state_q == ST_HOLD);
    assign rsp_id    = rsp_id_q;
    assign rsp_sum   = rsp_sum_q;
    assign rsp_cout  = rsp_cout_q;
    assign rsp_ovf   = rsp_ovf_q;

endmodule

// File: tb/tb_add_arb_16b.sv
// Scoreboard bench for add_arb_16b: expected responses are queued at grant time
// and popped when the response channel presents a result.
module tb_add_arb_16b;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0, req1, rsp_ready;
    logic [15:0] a0, b0, a1, b1;
    logic        ack0, ack1, rsp_valid, rsp_id, rsp_cout, rsp_ovf;
    logic [15:0] rsp_sum;

    typedef struct packed {
        logic        id;
        logic [15:0] sum;
        logic        cout;
        logic        ovf;
    } rsp_t;

    rsp_t sb[$];
    int   n_cmp = 0;
    int   n_err = 0;

    add_arb_16b dut (
        .clk       (clk),
        .rst       (rst),
        .req0      (req0),
        .a0        (a0),
        .b0        (b0),
        .ack0      (ack0),
        .req1      (req1),
        .a1        (a1),
        .b1        (b1),
        .ack1      (ack1),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_ovf   (rsp_ovf)
    );

    always #5 clk = ~clk;

    function automatic rsp_t model(input logic id, input logic [15:0] a, input logic [15:0] b);
        rsp_t        r;
        logic [16:0] t;
        t      = {1'b0, a} + {1'b0, b};
        r.id   = id;
        r.sum  = t[15:0];
        r.cout = t[16];
        r.ovf  = (a[15] == b[15]) && (t[15] != a[15]);
        return r;
    endfunction

    function automatic rsp_t observed();
        rsp_t r;
        r.id   = rsp_id;
        r.sum  = rsp_sum;
        r.cout = rsp_cout;
        r.ovf  = rsp_ovf;
        return r;
    endfunction

    task automatic test_reset();
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b1; req1 = 1'b1;
        @(negedge clk);
        n_cmp++;
        if ({ack0, ack1} !== 2'b00) begin
            n_err++;
            $display("FAIL reset_ack: got %b want 00", {ack0, ack1});
        end
        n_cmp++;
        if ({rsp_valid, observed()} !== '0) begin
            n_err++;
            $display("FAIL reset_rsp: got valid=%b rsp=%h want all zero", rsp_valid, observed());
        end
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b0; req1 = 1'b0;
    endtask

    task automatic test_single_op(input logic id, input logic [15:0] a, input logic [15:0] b,
                                  input string nm);
        rsp_t exp;
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        if (id) begin
            req1 = 1'b1; a1 = a; b1 = b;
        end else begin
            req0 = 1'b1; a0 = a; b0 = b;
        end
        @(negedge clk);
        n_cmp++;
        if ({ack0, ack1} !== (id ? 2'b01 : 2'b10)) begin
            n_err++;
            $display("FAIL %s_ack: got ack0/ack1=%b want %b", nm, {ack0, ack1},
                     id ? 2'b01 : 2'b10);
        end
        sb.push_back(model(id, a, b));
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        a0 = ~a; b0 = 16'h5a5a; a1 = ~a; b1 = 16'ha5a5;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, ack0, ack1} !== 3'b000) begin
            n_err++;
            $display("FAIL %s_add_cycle: got valid/ack0/ack1=%b want 000", nm,
                     {rsp_valid, ack0, ack1});
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1) begin
            n_err++;
            $display("FAIL %s_valid: got %b want 1", nm, rsp_valid);
        end
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (observed() !== exp) begin
            n_err++;
            $display("FAIL %s_rsp: got id=%b sum=%h cout=%b ovf=%b want id=%b sum=%h cout=%b ovf=%b",
                     nm, rsp_id, rsp_sum, rsp_cout, rsp_ovf, exp.id, exp.sum, exp.cout, exp.ovf);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL %s_idle: got valid=%b want 0", nm, rsp_valid);
        end
    endtask

    task automatic test_back_to_back();
        int   n_ack = 0;
        int   n_rsp = 0;
        int   cyc = 0;
        int   last_cyc = -100;
        logic exp_id = 1'b0;
        logic g0, g1;
        rsp_t exp;
        @(posedge clk); #1;
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0; rsp_ready = 1'b1; req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h1234; b0 = 16'h1111; a1 = 16'hF000; b1 = 16'h2000;
        while (n_rsp < 4 && cyc < 40) begin
            @(negedge clk);
            g0 = ack0; g1 = ack1;
            n_cmp++;
            if (g0 && g1) begin
                n_err++;
                $display("FAIL b2b_both_ack: got 11 want at most one at cycle %0d", cyc);
            end
            if (g0 || g1) begin
                n_cmp++;
                if (g1 !== exp_id) begin
                    n_err++;
                    $display("FAIL b2b_order: got ack id %b want %b", g1, exp_id);
                end
                if (n_ack > 0) begin
                    n_cmp++;
                    if (cyc - last_cyc != 3) begin
                        n_err++;
                        $display("FAIL b2b_spacing: got %0d want 3", cyc - last_cyc);
                    end
                end
                sb.push_back(g1 ? model(1'b1, a1, b1) : model(1'b0, a0, b0));
                last_cyc = cyc;
                exp_id = ~exp_id;
                n_ack++;
            end
            if (rsp_valid) begin
                exp = (sb.size() > 0) ? sb.pop_front() : '0;
                n_cmp++;
                if (observed() !== exp) begin
                    n_err++;
                    $display("FAIL b2b_rsp%0d: got %h want %h", n_rsp, observed(), exp);
                end
                n_rsp++;
            end
            @(posedge clk); #1;
            cyc++;
            if (g0) begin a0 = 16'($urandom); b0 = 16'($urandom); end
            if (g1) begin a1 = 16'($urandom); b1 = 16'($urandom); end
            if (n_ack >= 4) begin req0 = 1'b0; req1 = 1'b0; end
        end
        n_cmp++;
        if (n_ack != 4 || n_rsp != 4) begin
            n_err++;
            $display("FAIL b2b_count: got acks=%0d rsps=%0d want 4/4", n_ack, n_rsp);
        end
    endtask

    task automatic test_hold_stall();
        rsp_t exp;
        @(posedge clk); #1;
        rsp_ready = 1'b0; req0 = 1'b1; a0 = 16'h4000; b0 = 16'h4000;
        @(negedge clk);
        n_cmp++;
        if ({ack0, ack1} !== 2'b10) begin
            n_err++;
            $display("FAIL hold_ack0: got %b want 10", {ack0, ack1});
        end
        sb.push_back(model(1'b0, a0, b0));
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b1; a1 = 16'h0F0F; b1 = 16'h00F1;
        @(negedge clk);
        n_cmp++;
        if ({rsp_valid, ack1} !== 2'b00) begin
            n_err++;
            $display("FAIL hold_add_cycle: got valid/ack1=%b want 00", {rsp_valid, ack1});
        end
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            n_cmp++;
            if (rsp_valid !== 1'b1 || ack1 !== 1'b0 || observed() !== exp) begin
                n_err++;
                $display("FAIL hold_stall%0d: got valid=%b ack1=%b rsp=%h want 1 0 %h",
                         i, rsp_valid, ack1, observed(), exp);
            end
        end
        @(posedge clk); #1;
        rsp_ready = 1'b1;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b1 || ack1 !== 1'b0 || observed() !== exp) begin
            n_err++;
            $display("FAIL hold_accept: got valid=%b ack1=%b rsp=%h want 1 0 %h",
                     rsp_valid, ack1, observed(), exp);
        end
        @(negedge clk);
        n_cmp++;
        if ({ack0, ack1} !== 2'b01) begin
            n_err++;
            $display("FAIL hold_ack1_after: got %b want 01", {ack0, ack1});
        end
        sb.push_back(model(1'b1, a1, b1));
        @(posedge clk); #1;
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || observed() !== exp) begin
            n_err++;
            $display("FAIL hold_rsp1: got valid=%b rsp=%h want 1 %h", rsp_valid, observed(), exp);
        end
    endtask

    task automatic test_reset_mid();
        rsp_t exp;
        @(posedge clk); #1;
        rsp_ready = 1'b1; req0 = 1'b1; a0 = 16'h0101; b0 = 16'h0202;
        @(negedge clk);
        n_cmp++;
        if ({ack0, ack1} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_ack: got %b want 10", {ack0, ack1});
        end
        @(posedge clk); #1;
        req0 = 1'b0; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; req0 = 1'b1; req1 = 1'b1;
        a0 = 16'h00FF; b0 = 16'hFF01; a1 = 16'h1111; b1 = 16'h2222;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || rsp_sum !== 16'h0000) begin
            n_err++;
            $display("FAIL rstmid_discard: got valid=%b sum=%h want 0 0000", rsp_valid, rsp_sum);
        end
        n_cmp++;
        if ({ack0, ack1} !== 2'b10) begin
            n_err++;
            $display("FAIL rstmid_tie: got %b want 10", {ack0, ack1});
        end
        sb.push_back(model(1'b0, a0, b0));
        @(posedge clk); #1;
        req0 = 1'b0; req1 = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0) begin
            n_err++;
            $display("FAIL rstmid_add_cycle: got valid=%b want 0", rsp_valid);
        end
        @(negedge clk);
        exp = (sb.size() > 0) ? sb.pop_front() : '0;
        n_cmp++;
        if (rsp_valid !== 1'b1 || observed() !== exp) begin
            n_err++;
            $display("FAIL rstmid_rsp: got valid=%b rsp=%h want 1 %h", rsp_valid, observed(), exp);
        end
        @(negedge clk);
        n_cmp++;
        if (rsp_valid !== 1'b0 || sb.size() != 0) begin
            n_err++;
            $display("FAIL rstmid_end: got valid=%b pending=%0d want 0 0", rsp_valid, sb.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; req0 = 1'b0; req1 = 1'b0; rsp_ready = 1'b0;
        a0 = '0; b0 = '0; a1 = '0; b1 = '0;
        test_reset();
        test_single_op(1'b0, 16'h0001, 16'h0002, "basic");
        test_single_op(1'b1, 16'hFFFF, 16'h0001, "carry");
        test_single_op(1'b0, 16'h7FFF, 16'h0001, "ovf_pos");
        test_single_op(1'b0, 16'h8000, 16'h8000, "ovf_neg");
        test_back_to_back();
        test_hold_stall();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
